serial_word_queue: RTL and testbench

Parametrised serial-to-parallel receiver with an integrated word FIFO. It is the successor to the fixed 8-bit receive/queue top: same slow strobe-driven interface (write_in, enqueue_in, dequeue_in held for many cycles) and the same status handshake. It adds configurable word width, queue depth and bit order, plus occupancy, full/empty and error reporting. It sits directly behind the external bit-serial source at the 1 MHz system clock.

---
 rtl/serial_word_queue.sv | 216 +++++++++++++++++++++
 tb/tb_serial_word_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_queue.sv
// serial_word_queue: bit-serial receiver that assembles DATA_W-bit words and
// queues them in a DEPTH-entry FIFO. All strobes are slow levels; each one is
// synchronised and turned into a single rising-edge event.
`timescale 1ns/1ps
module serial_word_queue #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                         clock_1MHz,
    input  logic                         rst,
    input  logic                         data_in,
    input  logic                         write_in,
    input  logic                         enqueue_in,
    input  logic                         dequeue_in,
    output logic                         status_out,
    output logic [DATA_W-1:0]            data_out,
    output logic [$clog2(DEPTH+1)-1:0]   len_out,
    output logic                         full_out,
    output logic                         empty_out,
    output logic                         err_out
);

    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_RX   = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // Input bundle order: {dequeue, enqueue, write, data}
    logic [3:0]        sync1_r;
    logic [3:0]        sync2_r;
    logic [2:0]        prev_r;

    state_t            state_r;
    logic              status_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] shift_r;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [LEN_W-1:0]  len_r;
    logic              full_r;
    logic              empty_r;
    logic              err_r;
    logic [DATA_W-1:0] data_r;

    logic              bit_s;
    logic              wr_ev_s;
    logic              enq_ev_s;
    logic              deq_ev_s;
    logic              push_ok_s;
    logic              push_rej_s;
    logic              pop_ok_s;
    logic              pop_err_s;
    logic [LEN_W-1:0]  len_nxt_s;
    logic [BIT_W-1:0]  bit_idx_s;

    // Two-flop synchroniser plus previous-value register for edge detection.
    always_ff @(posedge clock_1MHz or posedge rst) begin
        if (rst) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
            prev_r  <= 3'b000;
        end else begin
            sync1_r <= {dequeue_in, enqueue_in, write_in, data_in};
            sync2_r <= sync1_r;
            prev_r  <= sync2_r[3:1];
        end
    end

    assign bit_s    = sync2_r[0];
    assign wr_ev_s  = sync2_r[1] & ~prev_r[0];
    assign enq_ev_s = sync2_r[2] & ~prev_r[1];
    assign deq_ev_s = sync2_r[3] & ~prev_r[2];

    // Push/pop qualification, all judged against the pre-cycle occupancy.
    always_comb begin
        push_ok_s  = 1'b0;
        push_rej_s = 1'b0;
        pop_ok_s   = 1'b0;
        pop_err_s  = 1'b0;
        if (deq_ev_s) begin
            pop_ok_s  = ~empty_r;
            pop_err_s = empty_r;
        end else begin
            pop_ok_s  = 1'b0;
            pop_err_s = 1'b0;
        end
        if (enq_ev_s && (state_r == ST_HOLD)) begin
            push_ok_s  = ~full_r | deq_ev_s;
            push_rej_s = full_r & ~deq_ev_s;
        end else begin
            push_ok_s  = 1'b0;
            push_rej_s = 1'b0;
        end
    end

    // Next occupancy from the up/down counter.
    always_comb begin
        len_nxt_s = len_r;
        if (push_ok_s && !pop_ok_s) begin
            len_nxt_s = len_r + LEN_W'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            len_nxt_s = len_r - LEN_W'(1);
        end else begin
            len_nxt_s = len_r;
        end
    end

    // Destination bit of the current serial bit within the word.
    always_comb begin
        bit_idx_s = bit_cnt_r;
        if (LSB_FIRST) begin
            bit_idx_s = bit_cnt_r;
        end else begin
            bit_idx_s = BIT_LAST - bit_cnt_r;
        end
    end

    // Receiver FSM: collect DATA_W bits, then hold the word until it is queued.
    always_ff @(posedge clock_1MHz or posedge rst) begin
        if (rst) begin
            state_r   <= ST_RX;
            status_r  <= 1'b1;
            bit_cnt_r <= {BIT_W{1'b0}};
            shift_r   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_RX: begin
                    if (wr_ev_s) begin
                        shift_r[bit_idx_s] <= bit_s;
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_r <= {BIT_W{1'b0}};
                            state_r   <= ST_HOLD;
                            status_r  <= 1'b0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (push_ok_s) begin
                        state_r  <= ST_RX;
                        status_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_RX;
                    status_r  <= 1'b1;
                    bit_cnt_r <= {BIT_W{1'b0}};
                end
            endcase
        end
    end

    // Word storage; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clock_1MHz) begin
        if (push_ok_s) begin
            mem_r[tail_r] <= shift_r;
        end
    end

    // Queue pointers, occupancy flags, popped word and sticky error.
    always_ff @(posedge clock_1MHz or posedge rst) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            len_r   <= {LEN_W{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            err_r   <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                tail_r <= ptr_next(tail_r);
            end
            if (pop_ok_s) begin
                data_r <= mem_r[head_r];
                head_r <= ptr_next(head_r);
            end
            if (push_rej_s || pop_err_s) begin
                err_r <= 1'b1;
            end
            len_r   <= len_nxt_s;
            full_r  <= (len_nxt_s == LEN_FULL);
            empty_r <= (len_nxt_s == {LEN_W{1'b0}});
        end
    end

    assign status_out = status_r;
    assign data_out   = data_r;
    assign len_out    = len_r;
    assign full_out   = full_r;
    assign empty_out  = empty_r;
    assign err_out    = err_r;

endmodule

// File: tb/tb_serial_word_queue.sv
// Bench for serial_word_queue: two instances (LSB-first and MSB-first) share
// the same stimulus; a queue-based model is checked every cycle.
`timescale 1ns/1ps
module tb_serial_word_queue;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int LW = $clog2(D + 1);
    localparam int HI = 10;
    localparam int LO = 10;

    logic clk = 1'b0;
    logic rst, data_in, write_in, enqueue_in, dequeue_in;
    logic sa, fa, ea, era, sb, fb, eb, erb;
    logic [W-1:0]  da, db;
    logic [LW-1:0] la, lb;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state: queued words in LSB-first bit order.
    logic [W-1:0] m_q[$];
    logic         m_bits[$];
    logic         m_rx;
    logic         m_err;
    logic [W-1:0] m_word;
    logic [W-1:0] m_data;

    always #500 clk = ~clk;

    serial_word_queue #(.DATA_W(W), .DEPTH(D), .LSB_FIRST(1'b1)) dut_a (
        .clock_1MHz(clk), .rst(rst), .data_in(data_in), .write_in(write_in),
        .enqueue_in(enqueue_in), .dequeue_in(dequeue_in), .status_out(sa),
        .data_out(da), .len_out(la), .full_out(fa), .empty_out(ea), .err_out(era)
    );

    serial_word_queue #(.DATA_W(W), .DEPTH(D), .LSB_FIRST(1'b0)) dut_b (
        .clock_1MHz(clk), .rst(rst), .data_in(data_in), .write_in(write_in),
        .enqueue_in(enqueue_in), .dequeue_in(dequeue_in), .status_out(sb),
        .data_out(db), .len_out(lb), .full_out(fb), .empty_out(eb), .err_out(erb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[W-1-i];
        return r;
    endfunction

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("status_a", 32'(sa),  32'(m_rx));
            chk("data_a",   32'(da),  32'(m_data));
            chk("len_a",    32'(la),  32'(m_q.size()));
            chk("full_a",   32'(fa),  32'(m_q.size() == D));
            chk("empty_a",  32'(ea),  32'(m_q.size() == 0));
            chk("err_a",    32'(era), 32'(m_err));
            chk("status_b", 32'(sb),  32'(m_rx));
            chk("data_b",   32'(db),  32'(rev(m_data)));
            chk("len_b",    32'(lb),  32'(m_q.size()));
            chk("full_b",   32'(fb),  32'(m_q.size() == D));
            chk("empty_b",  32'(eb),  32'(m_q.size() == 0));
            chk("err_b",    32'(erb), 32'(m_err));
        end
    end

    task automatic model_reset();
        m_q.delete();
        m_bits.delete();
        m_rx   = 1'b1;
        m_err  = 1'b0;
        m_word = '0;
        m_data = '0;
    endtask

    // Effect of one event set on the abstract receiver/queue.
    task automatic model_apply(input logic w, input logic b, input logic e, input logic d);
        int   pre;
        logic rx0;
        pre = m_q.size();
        rx0 = m_rx;
        if (w && rx0) begin
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                m_word = '0;
                for (int i = 0; i < W; i++) if (m_bits[i]) m_word[i] = 1'b1;
                m_bits.delete();
                m_rx = 1'b0;
            end
        end
        if (d) begin
            if (pre == 0) m_err = 1'b1;
            else m_data = m_q.pop_front();
        end
        if (e && !rx0) begin
            if (pre < D || (d && pre > 0)) begin
                m_q.push_back(m_word);
                m_rx = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    // Raise strobes at a negedge; their effect lands on the third rising edge.
    task automatic pulse(input logic w, input logic b, input logic e, input logic d);
        @(negedge clk);
        data_in    = b;
        write_in   = w;
        enqueue_in = e;
        dequeue_in = d;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        model_apply(w, b, e, d);
        repeat (HI - 2) @(negedge clk);
        write_in   = 1'b0;
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        repeat (LO - 1) @(negedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] x);
        for (int i = 0; i < W; i++) pulse(1'b1, x[i], 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst        = 1'b1;
        data_in    = 1'b0;
        write_in   = 1'b0;
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        data_in    = 1'b0;
        write_in   = 1'b0;
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        chk("rst_status", 32'(sa), 32'd1);
        chk("rst_empty",  32'(ea), 32'd1);
        chk("rst_full",   32'(fa), 32'd0);
        chk("rst_len",    32'(la), 32'd0);
        chk("rst_data",   32'(da), 32'h00);
        chk("rst_err",    32'(era), 32'd0);

        // Enqueue while receiving is ignored
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rx_enq_len", 32'(la), 32'd0);
        chk("rx_enq_err", 32'(era), 32'd0);

        // 0xAA LSB first through both bit orders
        send_word(8'hAA);
        chk("hold_status_a", 32'(sa), 32'd0);
        chk("hold_status_b", 32'(sb), 32'd0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("enq_status", 32'(sa), 32'd1);
        chk("enq_len",    32'(la), 32'd1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pop_aa",  32'(da), 32'hAA);
        chk("pop_55",  32'(db), 32'h55);
        chk("pop_len", 32'(la), 32'd0);

        // Empty pop: sticky error, data unchanged
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("epop_err",  32'(era), 32'd1);
        chk("epop_data", 32'(da), 32'hAA);
        send_word(8'h5A);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pop_5a",      32'(da), 32'h5A);
        chk("sticky_err",  32'(era), 32'd1);
        do_reset();
        chk("rst_err_clr", 32'(era), 32'd0);

        // Fill, overflow, then accept after a pop
        for (int v = 1; v <= D; v++) begin
            send_word(8'(v));
            pulse(1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("fill_full", 32'(fa), 32'd1);
        chk("fill_len",  32'(la), 32'd8);
        chk("fill_err",  32'(era), 32'd0);
        send_word(8'h09);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_err",    32'(era), 32'd1);
        chk("ovf_len",    32'(la), 32'd8);
        chk("ovf_status", 32'(sa), 32'd0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        chk("hold_wr_status", 32'(sa), 32'd0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_pop", 32'(da), 32'h01);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_acc_status", 32'(sa), 32'd1);
        chk("ovf_acc_len",    32'(la), 32'd8);
        for (int v = 2; v <= 9; v++) begin
            pulse(1'b0, 1'b0, 1'b0, 1'b1);
            chk("drain1", 32'(da), 32'(v));
        end
        chk("drain1_empty", 32'(ea), 32'd1);

        // Simultaneous enqueue/dequeue while full
        do_reset();
        for (int v = 1; v <= D; v++) begin
            send_word(8'(v));
            pulse(1'b0, 1'b0, 1'b1, 1'b0);
        end
        send_word(8'h99);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        chk("sim_data",   32'(da), 32'h01);
        chk("sim_len",    32'(la), 32'd8);
        chk("sim_status", 32'(sa), 32'd1);
        chk("sim_err",    32'(era), 32'd0);
        for (int v = 2; v <= D; v++) begin
            pulse(1'b0, 1'b0, 1'b0, 1'b1);
            chk("drain2", 32'(da), 32'(v));
        end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("drain2_99",    32'(da), 32'h99);
        chk("drain2_empty", 32'(ea), 32'd1);

        // Reset mid-word and mid-queue
        do_reset();
        send_word(8'h11);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'h22);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'h33);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        chk("mid_len", 32'(la), 32'd3);
        do_reset();
        chk("mid_rst_len",   32'(la), 32'd0);
        chk("mid_rst_empty", 32'(ea), 32'd1);
        send_word(8'h3C);
        chk("mid_hold", 32'(sa), 32'd0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("mid_3c_a", 32'(da), 32'h3C);
        chk("mid_3c_b", 32'(db), 32'h3C);

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
